addsub_result_fifo: RTL and testbench
=====================================

Name: addsub_result_fifo

Overview:
Downstream stage of the 4-bit ripple adder-subtractor. Captures each adder/subtractor result and the operands that produced it, and derives status flags: zero, negative, signed overflow, unsigned borrow. Also checks the result arithmetically. Buffers results in a small FIFO with valid/ready handshakes on both sides, so a slow consumer can back-pressure the producer.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNT_W, 8, width of the accepted-operation counter; wraps modulo 2^CNT_W.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  producer has a result this cycle
in_ready  output  1  block can accept a result this cycle
in_a  input  4  operand A presented to the adder
in_b  input  4  operand B presented to the adder (before inversion)
in_sub  input  1  mode bit: 0 = add, 1 = subtract (also the adder carry-in)
in_sum  input  4  adder sum output
in_carry  input  1  adder final carry-out
out_valid  output  1  head entry available
out_ready  input  1  consumer takes head entry this cycle
out_sum  output  4  head: stored sum
out_carry  output  1  head: stored carry-out
out_zero  output  1  head: sum == 0
out_neg  output  1  head: sum[3]
out_ovf  output  1  head: two's-complement overflow
out_borrow  output  1  head: unsigned borrow (subtract only)
level  output  clog2(DEPTH)+1  current FIFO occupancy
op_count  output  CNT_W  number of accepted results since reset
chk_err  output  1  sticky: some accepted sum/carry disagreed with the operands

Behaviour:
- Reset (rst=1 at a clk edge): level=0, out_valid=0, in_ready=1, op_count=0, chk_err=0.
  - Reset drops all stored entries, including entries mid-transfer.
  - out_sum, out_carry and all out_* flags read 0 while empty.
- Push: occurs when in_valid && in_ready at the edge; op_count increments.
- Pop: occurs when out_valid && out_ready at the edge.
- in_ready = (level < DEPTH). It is computed from registered state only and never depends on out_ready.
  - A full FIFO does not accept a push, even when a pop occurs in the same cycle.
- out_valid = (level != 0). Head fields come from storage registers, not from a combinational bypass.
- Latency: a push into an empty FIFO shows out_valid=1 with that entry's fields on the next cycle.
- Simultaneous push and pop with 0 < level < DEPTH: level unchanged, order preserved, new entry written at the tail.
- Pointers: rd_ptr and wr_ptr wrap modulo DEPTH. level saturates neither up nor down; illegal pushes and pops are blocked by the handshake.
- Flag computation happens at push time from the input bus, and the flags are stored with the entry. Let bx = in_b XOR {4{in_sub}}.
  - zero = (in_sum == 4'h0)
  - neg = in_sum[3]
  - ovf = (in_a[3] == bx[3]) && (in_sum[3] != in_a[3])
  - borrow = in_sub && !in_carry; forced 0 when in_sub=0
- Stored carry is in_carry as given.
- Checker: at each push, compute the 5-bit value {c,s} = in_a + bx + in_sub.
  - If s != in_sum or c != in_carry, set chk_err=1 on that edge.
  - chk_err stays set until rst. Stored fields are still the input values, not the recomputed ones.
- op_count wraps from 2^CNT_W-1 to 0 without a flag.
- Pushes and pops with in_valid/out_ready asserted during rst are ignored.

Test Plan:
- Reset, then push a=5, b=3, sub=0, sum=8, carry=0.
  - Next cycle: out_valid=1, sum=8, carry=0, zero=0, neg=1, ovf=1, borrow=0, level=1, op_count=1.
- Push a=3, b=5, sub=1, sum=E, carry=0 -> out_sum=E, neg=1, ovf=0, borrow=1, zero=0, chk_err=0.
- Push a=7, b=7, sub=1, sum=0, carry=1 -> zero=1, carry=1, borrow=0, ovf=0.
- Hold out_ready=0 and push 4 distinct results.
  - After the 4th push: level=4, in_ready=0; a 5th push held with in_valid=1 is not taken.
  - With out_ready=1 for 4 cycles: entries emerge in push order, then the 5th push is taken.
- Streaming at level=2 with in_valid=out_ready=1 for 10 cycles -> level stays 2, outputs in order, op_count advances by 10, pointers wrap cleanly.
- Push a=1, b=1, sub=0, sum=0, carry=0 -> chk_err=1 and it stays 1 through later correct pushes.
  - Then pulse rst with 3 entries stored -> level=0, out_valid=0, chk_err=0, op_count=0.

Source files
------------

// File: rtl/addsub_result_fifo.sv
// Result buffer behind the 4-bit adder-subtractor: stores each result with its
// status flags, cross-checks the arithmetic, and queues entries with valid/ready on both sides.
module addsub_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic                     in_sub,
  input  logic [3:0]               in_sum,
  input  logic                     in_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_sum,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_ovf,
  output logic                     out_borrow,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         op_count,
  output logic                     chk_err
);

  localparam int PW      = $clog2(DEPTH);
  localparam int LW      = PW + 1;
  localparam int ENTRY_W = 9;

  localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
  localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]    LVL_ZERO = LW'(0);
  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Entry layout: {sum[3:0], carry, zero, neg, ovf, borrow}
  function automatic logic [ENTRY_W-1:0] packEntry(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       sub,
    input logic [3:0] sum,
    input logic       carry
  );
    logic [3:0] bx;
    logic       zero;
    logic       neg;
    logic       ovf;
    logic       borrow;
    bx     = b ^ {4{sub}};
    zero   = (sum == 4'h0);
    neg    = sum[3];
    ovf    = (a[3] == bx[3]) && (sum[3] != a[3]);
    borrow = sub && !carry;
    return {sum, carry, zero, neg, ovf, borrow};
  endfunction

  // Recomputes the adder result and reports any disagreement with the bus.
  function automatic logic sumMismatch(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       sub,
    input logic [3:0] sum,
    input logic       carry
  );
    logic [3:0] bx;
    logic [4:0] ref5;
    bx   = b ^ {4{sub}};
    ref5 = {1'b0, a} + {1'b0, bx} + {4'b0000, sub};
    return (ref5[3:0] != sum) || (ref5[4] != carry);
  endfunction

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]      wrPtr_r;
  logic [PW-1:0]      rdPtr_r;
  logic [LW-1:0]      level_r;
  logic               inReady_r;
  logic               outValid_r;
  logic [CNT_W-1:0]   opCount_r;
  logic               chkErr_r;

  logic               pushEn_s;
  logic               popEn_s;
  logic [LW-1:0]      nextLevel_s;
  logic [ENTRY_W-1:0] newEntry_s;
  logic               newBad_s;
  logic [ENTRY_W-1:0] headEntry_s;

  // Handshake decode, next occupancy and the entry/check derived from the input bus.
  always_comb begin
    pushEn_s    = in_valid && inReady_r;
    popEn_s     = out_ready && outValid_r;
    newEntry_s  = packEntry(in_a, in_b, in_sub, in_sum, in_carry);
    newBad_s    = sumMismatch(in_a, in_b, in_sub, in_sum, in_carry);
    nextLevel_s = level_r;
    case ({pushEn_s, popEn_s})
      2'b10:   nextLevel_s = level_r + LVL_ONE;
      2'b01:   nextLevel_s = level_r - LVL_ONE;
      default: nextLevel_s = level_r;
    endcase
  end

  // Storage, pointers, occupancy and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wrPtr_r    <= '0;
      rdPtr_r    <= '0;
      level_r    <= LVL_ZERO;
      inReady_r  <= 1'b1;
      outValid_r <= 1'b0;
      opCount_r  <= '0;
      chkErr_r   <= 1'b0;
    end else begin
      if (pushEn_s) begin
        mem_r[wrPtr_r] <= newEntry_s;
        wrPtr_r        <= wrPtr_r + PTR_ONE;
        opCount_r      <= opCount_r + CNT_ONE;
        if (newBad_s) begin
          chkErr_r <= 1'b1;
        end
      end
      if (popEn_s) begin
        rdPtr_r <= rdPtr_r + PTR_ONE;
      end
      // Ready/valid are kept as flops so neither depends on the consumer's out_ready.
      level_r    <= nextLevel_s;
      inReady_r  <= (nextLevel_s < LVL_FULL);
      outValid_r <= (nextLevel_s != LVL_ZERO);
    end
  end

  // Head fields read straight from storage and forced to zero while empty.
  always_comb begin
    headEntry_s = mem_r[rdPtr_r];
    if (outValid_r) begin
      {out_sum, out_carry, out_zero, out_neg, out_ovf, out_borrow} = headEntry_s;
    end else begin
      {out_sum, out_carry, out_zero, out_neg, out_ovf, out_borrow} = '0;
    end
  end

  assign in_ready  = inReady_r;
  assign out_valid = outValid_r;
  assign level     = level_r;
  assign op_count  = opCount_r;
  assign chk_err   = chkErr_r;

endmodule

// File: tb/tb_addsub_result_fifo.sv
// Self-checking bench for addsub_result_fifo: directed vector table, hand-written
// full/stream/error/reset sequences, and random traffic against a queue-based model.
module tb_addsub_result_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_ready, in_sub, in_carry, out_valid, out_ready;
  logic [3:0] in_a, in_b, in_sum, out_sum;
  logic out_carry, out_zero, out_neg, out_ovf, out_borrow, chk_err;
  logic [2:0] level;
  logic [CNT_W-1:0] op_count;

  addsub_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry),
    .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf), .out_borrow(out_borrow),
    .level(level), .op_count(op_count), .chk_err(chk_err)
  );

  typedef struct {
    logic [3:0] sum;
    logic carry, zero, neg, ovf, borrow;
  } ent_t;

  typedef struct {
    logic [3:0] a, b; logic sub; logic [3:0] sum; logic carry;
    logic [3:0] eSum; logic eCarry, eZero, eNeg, eOvf, eBorrow, eChk;
  } vec_t;

  ent_t mq[$];
  logic [CNT_W-1:0] mCount;
  logic mChk;
  int tests = 0;
  int fails = 0;
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Flags from their definitions: sign of a, sign of the effective second operand.
  function automatic ent_t mkEnt(input logic [3:0] a, b, input logic sub, input logic [3:0] sum, input logic carry);
    ent_t e;
    bit aNeg, bxNeg, sNeg;
    aNeg  = (a >= 8);
    bxNeg = sub ? (b < 8) : (b >= 8);
    sNeg  = (sum >= 8);
    e.sum = sum; e.carry = carry;
    e.zero = (sum == 0); e.neg = sNeg;
    e.ovf = (aNeg == bxNeg) && (sNeg != aNeg);
    e.borrow = sub && !carry;
    return e;
  endfunction

  function automatic void goodResult(input int a, b, input bit sub, output logic [3:0] s, output logic c);
    int t;
    t = sub ? (a - b + 16) : (a + b);
    s = 4'(t % 16);
    c = (t >= 16);
  endfunction

  function automatic bit isBad(input logic [3:0] a, b, input logic sub, input logic [3:0] sum, input logic carry);
    logic [3:0] s; logic c;
    goodResult(int'(a), int'(b), sub, s, c);
    return (s != sum) || (c != carry);
  endfunction

  task automatic compareState(input string nm);
    logic [22:0] act, exp;
    ent_t h;
    h = '{default: '0};
    if (mq.size() > 0) h = mq[0];
    exp = {mq.size() != 0, mq.size() < DEPTH, 3'(mq.size()), mCount, mChk,
           h.sum, h.carry, h.zero, h.neg, h.ovf, h.borrow};
    act = {out_valid, in_ready, level, op_count, chk_err,
           out_sum, out_carry, out_zero, out_neg, out_ovf, out_borrow};
    chk(nm, 32'(act), 32'(exp));
  endtask

  task automatic step(input logic v, input logic [3:0] a, b, input logic sub,
                      input logic [3:0] sum, input logic carry, input logic rdy, output bit pushed);
    in_valid = v; in_a = a; in_b = b; in_sub = sub; in_sum = sum; in_carry = carry; out_ready = rdy;
    @(posedge clk);
    pushed = v && (mq.size() < DEPTH);
    if (rdy && mq.size() > 0) mq.delete(0);
    if (pushed) begin
      mq.push_back(mkEnt(a, b, sub, sum, carry));
      mCount++;
      if (isBad(a, b, sub, sum, carry)) mChk = 1'b1;
    end
    #1;
    compareState("state");
  endtask

  task automatic doReset();
    in_valid = 1'b1; out_ready = 1'b1; in_a = 4'h2; in_b = 4'h2; in_sub = 1'b0; in_sum = 4'h4; in_carry = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    mq.delete(); mCount = '0; mChk = 1'b0;
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    compareState("reset_state");
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_chk", 32'(chk_err), 32'd0);
  endtask

  task automatic drain();
    bit p;
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (mq.size() > 0) step(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, p);
    end
    chk("drained", 32'(level), 32'd0);
  endtask

  task automatic randOp(input bit corrupt, output logic [3:0] a, b, output logic sub, output logic [3:0] s, output logic c);
    a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); sub = 1'($urandom_range(0, 1));
    goodResult(int'(a), int'(b), sub, s, c);
    if (corrupt) s = s ^ 4'($urandom_range(1, 15));
  endtask

  initial begin
    bit p, pending;
    logic [3:0] ra, rb, rs; logic rsub, rc;
    logic [CNT_W-1:0] startCount;
    //          a     b     sub   sum   c     eSum  eC    eZ    eN    eO    eB    eChk
    vecs[0] = '{4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{4'h7, 4'h7, 1'b1, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 4'h0; in_b = 4'h0; in_sub = 1'b0; in_sum = 4'h0; in_carry = 1'b0;
    mCount = '0; mChk = 1'b0;
    repeat (2) @(posedge clk);
    doReset();

    // Directed vectors: push into empty FIFO, check head one cycle later, then pop.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].carry, 1'b0, p);
      chk($sformatf("vec%0d_head", i),
          32'({out_valid, level, out_sum, out_carry, out_zero, out_neg, out_ovf, out_borrow, chk_err}),
          32'({1'b1, 3'd1, vecs[i].eSum, vecs[i].eCarry, vecs[i].eZero, vecs[i].eNeg,
               vecs[i].eOvf, vecs[i].eBorrow, vecs[i].eChk}));
      if (i == 0) chk("vec0_count", 32'(op_count), 32'd1);
      step(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, p);
    end

    // Fill to DEPTH with consumer stalled; fifth push must be refused.
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 1), 4'h2, 1'b0, 4'(i + 3), 1'b0, 1'b0, p);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_level", 32'(level), 32'd4);
    step(1'b1, 4'h9, 4'h4, 1'b1, 4'h5, 1'b1, 1'b0, p);
    chk("full_no_push", 32'(p), 32'd0);
    chk("full_level_held", 32'(level), 32'd4);
    pending = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(pending, 4'h9, 4'h4, 1'b1, 4'h5, 1'b1, 1'b1, p);
      if (i == 0) chk("full_pop_no_push", 32'(p), 32'd0);
      if (p) pending = 1'b0;
    end
    chk("fifth_taken", 32'(pending), 32'd0);
    drain();

    // Streaming at level 2 for 10 cycles.
    for (int i = 0; i < 2; i++) begin
      randOp(1'b0, ra, rb, rsub, rs, rc);
      step(1'b1, ra, rb, rsub, rs, rc, 1'b0, p);
    end
    startCount = mCount;
    for (int i = 0; i < 10; i++) begin
      randOp(1'b0, ra, rb, rsub, rs, rc);
      step(1'b1, ra, rb, rsub, rs, rc, 1'b1, p);
      chk("stream_level", 32'(level), 32'd2);
    end
    chk("stream_count", 32'(op_count), 32'(CNT_W'(startCount + CNT_W'(10))));
    drain();

    // Bad result sets sticky error; correct pushes afterwards do not clear it.
    step(1'b1, 4'h1, 4'h1, 1'b0, 4'h0, 1'b0, 1'b0, p);
    chk("chk_set", 32'(chk_err), 32'd1);
    step(1'b1, 4'h2, 4'h3, 1'b0, 4'h5, 1'b0, 1'b0, p);
    step(1'b1, 4'h6, 4'h2, 1'b1, 4'h4, 1'b1, 1'b0, p);
    chk("chk_sticky", 32'(chk_err), 32'd1);
    chk("pre_reset_level", 32'(level), 32'd3);
    doReset();

    // Random traffic including occasional wrong sums, long enough to wrap op_count.
    for (int i = 0; i < 400; i++) begin
      randOp($urandom_range(0, 15) == 0, ra, rb, rsub, rs, rc);
      step(1'($urandom_range(0, 3) != 0), ra, rb, rsub, rs, rc, 1'($urandom_range(0, 2) != 0), p);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
